// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame-size constants,
// the parity rule and the configuration decode helpers used by both link ends.
package uart_pkg;

    localparam int unsigned DATA_W = 9;

    localparam logic [3:0] DATA_SIZE_6 = 4'd6;
    localparam logic [3:0] DATA_SIZE_7 = 4'd7;
    localparam logic [3:0] DATA_SIZE_8 = 4'd8;
    localparam logic [3:0] DATA_SIZE_9 = 4'd9;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    typedef enum logic {
        PARITY_ODD  = 1'b0,
        PARITY_EVEN = 1'b1
    } parity_e;

    // Frame configuration captured when a start bit is accepted.
    typedef struct packed {
        logic [3:0] nbits;
        logic       par_en;
        parity_e    par_type;
        logic [1:0] nstop;
    } rx_cfg_t;

    function automatic logic [3:0] data_bits(input logic [3:0] data_size);
        logic [3:0] n;
        case (data_size)
            DATA_SIZE_6: n = DATA_SIZE_6;
            DATA_SIZE_7: n = DATA_SIZE_7;
            DATA_SIZE_8: n = DATA_SIZE_8;
            default:     n = DATA_SIZE_9;
        endcase
        return n;
    endfunction

    // 2 or 3 selects two stop bits, 0 or 1 selects one.
    function automatic logic [1:0] stop_bits(input logic [1:0] stop_size);
        return stop_size[1] ? 2'd2 : 2'd1;
    endfunction

    function automatic logic parity_bit(input logic [DATA_W-1:0] data, input parity_e ptype);
        return (ptype == PARITY_EVEN) ? ^data : ~^data;
    endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// Received-word handshake between the UART receive framer and its consumer.
interface uart_rx_frame_if;
    import uart_pkg::*;

    logic [DATA_W-1:0] data_o;
    logic              rx_valid_o;
    logic              parity_err_o;
    logic              frame_err_o;
    logic              overrun_o;
    logic              rx_ready_i;

    modport master (
        output data_o, rx_valid_o, parity_err_o, frame_err_o, overrun_o,
        input  rx_ready_i
    );

    modport slave (
        input  data_o, rx_valid_o, parity_err_o, frame_err_o, overrun_o,
        output rx_ready_i
    );

endinterface

// File: rtl/uart_rx_sync.sv
// rx line metastability synchroniser plus the "line seen high in IDLE" arm flag
// that blocks new starts on a line held low (break).
module uart_rx_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic rx_i,
    input  logic disarm_i,
    output logic rx_s_o,
    output logic armed_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   armed_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '1;
            armed_q <= 1'b0;
        end else begin
            sync_q  <= SYNC_STAGES'({sync_q, rx_i});
            armed_q <= disarm_i ? 1'b0 : (armed_q | sync_q[SYNC_STAGES-1]);
        end
    end

    assign rx_s_o  = sync_q[SYNC_STAGES-1];
    assign armed_o = armed_q;

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer: oversampled start/data/parity/stop recovery with a
// valid/ready output holding register. UART_RX_MAJORITY_VOTE_EN selects 2-of-3 bit voting.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic        tick_i,
    input  logic        rx_i,
    input  logic [3:0]  data_size_i,
    input  logic        parity_size_i,
    input  logic        parity_type_i,
    input  logic [1:0]  stop_size_i,
    output logic        rx_busy_o,
    uart_rx_frame_if.master rx_if
);

    localparam int unsigned CW = $clog2(OVERSAMPLE);

    logic rx_s;
    logic armed;
    logic disarm_c;

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .rx_i     (rx_i),
        .disarm_i (disarm_c),
        .rx_s_o   (rx_s),
        .armed_o  (armed)
    );

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sample_c;
    logic          bit_c;

`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [CW-1:0] VOTE0_PT  = CW'(OVERSAMPLE/2 - 2);
    localparam logic [CW-1:0] VOTE1_PT  = CW'(OVERSAMPLE/2 - 1);
    localparam logic [CW-1:0] SAMPLE_PT = CW'(OVERSAMPLE/2);

    logic vote0_q, vote1_q;

    // Early votes; the third is the live sample at the decision tick.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vote0_q <= 1'b1;
            vote1_q <= 1'b1;
        end else if (tick_i) begin
            if (cnt_q == VOTE0_PT) vote0_q <= rx_s;
            if (cnt_q == VOTE1_PT) vote1_q <= rx_s;
        end
    end

    assign bit_c = (vote0_q & vote1_q) | (vote0_q & rx_s) | (vote1_q & rx_s);
`else
    localparam logic [CW-1:0] SAMPLE_PT = CW'(OVERSAMPLE/2 - 1);

    assign bit_c = rx_s;
`endif

    assign sample_c = tick_i && (cnt_q == SAMPLE_PT);

    rx_state_e         state_q, state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;
    rx_cfg_t           cfg_q, cfg_d;
    logic              done_q, done_d;

    logic [DATA_W-1:0] dout_q, dout_d;
    logic              valid_q, valid_d;
    logic              pe_q, pe_d;
    logic              fe_q, fe_d;
    logic              ovr_q, ovr_d;
    logic              busy_q, busy_d;
    logic              accept_c;

    assign disarm_c = (state_q != IDLE);
    assign accept_c = valid_q && rx_if.rx_ready_i;

    // Next-state, frame datapath and output holding register.
    always_comb begin
        state_d   = state_q;
        cnt_d     = tick_i ? cnt_q + CW'(1) : cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        cfg_d     = cfg_q;
        done_d    = 1'b0;
        valid_d   = valid_q;
        dout_d    = dout_q;
        pe_d      = pe_q;
        fe_d      = fe_q;
        ovr_d     = 1'b0;

        if (!en_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (armed && !rx_s) begin
                        state_d        = START;
                        cnt_d          = '0;
                        bit_cnt_d      = '0;
                        shift_d        = '0;
                        perr_d         = 1'b0;
                        ferr_d         = 1'b0;
                        cfg_d.nbits    = data_bits(data_size_i);
                        cfg_d.par_en   = parity_size_i;
                        cfg_d.par_type = parity_e'(parity_type_i);
                        cfg_d.nstop    = stop_bits(stop_size_i);
                    end
                end
                START: begin
                    if (sample_c) begin
                        state_d   = bit_c ? IDLE : DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    if (sample_c) begin
                        shift_d[bit_cnt_q] = bit_c;
                        if (bit_cnt_q == cfg_q.nbits - 4'd1) begin
                            bit_cnt_d = '0;
                            state_d   = cfg_q.par_en ? PARITY : STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                PARITY: begin
                    if (sample_c) begin
                        perr_d  = (bit_c != parity_bit(shift_q, cfg_q.par_type));
                        state_d = STOP;
                    end
                end
                STOP: begin
                    if (sample_c) begin
                        if (!bit_c) ferr_d = 1'b1;
                        // Leave mid-bit so a start edge half a bit later is caught.
                        if (bit_cnt_q == 4'(cfg_q.nstop) - 4'd1) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (done_q) begin
            if (valid_q && !accept_c) begin
                ovr_d = 1'b1;
            end else begin
                valid_d = 1'b1;
                dout_d  = shift_q;
                pe_d    = perr_q;
                fe_d    = ferr_q;
            end
        end else if (accept_c) begin
            valid_d = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            cfg_q     <= '0;
            done_q    <= 1'b0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            pe_q      <= 1'b0;
            fe_q      <= 1'b0;
            ovr_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            cfg_q     <= cfg_d;
            done_q    <= done_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            pe_q      <= pe_d;
            fe_q      <= fe_d;
            ovr_q     <= ovr_d;
            busy_q    <= busy_d;
        end
    end

    assign rx_if.data_o       = dout_q;
    assign rx_if.rx_valid_o   = valid_q;
    assign rx_if.parity_err_o = pe_q;
    assign rx_if.frame_err_o  = fe_q;
    assign rx_if.overrun_o    = ovr_q;
    assign rx_busy_o          = busy_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed and randomized frames against a frame-level reference model of the UART receiver.
module tb_uart_rx_frame;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       en_i = 1'b1;
    logic       tick_i = 1'b0;
    logic       rx_i = 1'b1;
    logic [3:0] data_size_i = 4'd8;
    logic       parity_size_i = 1'b0;
    logic       parity_type_i = 1'b0;
    logic [1:0] stop_size_i = 2'd0;
    logic       rx_busy_o;

    uart_rx_frame_if rx_if ();

    uart_rx_frame #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .en_i          (en_i),
        .tick_i        (tick_i),
        .rx_i          (rx_i),
        .data_size_i   (data_size_i),
        .parity_size_i (parity_size_i),
        .parity_type_i (parity_type_i),
        .stop_size_i   (stop_size_i),
        .rx_busy_o     (rx_busy_o),
        .rx_if         (rx_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } word_t;

    word_t obs_q[$];
    int    valid_cycles = 0;
    int    ovr_pulses = 0;
    int    n_tests = 0;
    int    n_fail = 0;

    // Record every accepted word and count valid cycles / overrun pulses.
    always @(negedge clk) begin
        if (rx_if.rx_valid_o) valid_cycles++;
        if (rx_if.overrun_o) ovr_pulses++;
        if (rx_if.rx_valid_o && rx_if.rx_ready_i)
            obs_q.push_back('{d: rx_if.data_o, pe: rx_if.parity_err_o, fe: rx_if.frame_err_o});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int nbits_of(input logic [3:0] ds);
        return (ds == 4'd6) ? 6 : (ds == 4'd7) ? 7 : (ds == 4'd8) ? 8 : 9;
    endfunction

    function automatic logic par_rule(input logic [8:0] d, input logic even);
        return even ? ^d : ~^d;
    endfunction

    // What the receiver must report for a frame sent with these fields.
    function automatic word_t model(input logic [3:0] ds, input logic pen, input logic peven,
                                    input logic [1:0] ss, input logic [8:0] data,
                                    input logic par_sent, input logic [1:0] stops);
        word_t w;
        int    ns;
        ns   = (ss >= 2'd2) ? 2 : 1;
        w.d  = data & 9'((1 << nbits_of(ds)) - 1);
        w.pe = pen && (par_sent != par_rule(w.d, peven));
        w.fe = !stops[0] || (ns == 2 && !stops[1]);
        return w;
    endfunction

    task automatic ticks(input int n);
        repeat (n) begin
            @(negedge clk) tick_i = 1'b1;
            @(negedge clk) tick_i = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 rx_if.rx_ready_i = v;
    endtask

    // Drive one frame; configuration inputs are scrambled once the start bit is taken.
    task automatic send_frame(input logic [3:0] ds, input logic pen, input logic peven,
                              input logic [1:0] ss, input logic [8:0] data,
                              input logic par_sent, input logic [1:0] stops, input int idle);
        int nb;
        int ns;
        nb = nbits_of(ds);
        ns = (ss >= 2'd2) ? 2 : 1;
        data_size_i = ds; parity_size_i = pen; parity_type_i = peven; stop_size_i = ss;
        rx_i = 1'b0;
        ticks(4);
        data_size_i   = 4'($urandom);
        parity_size_i = 1'($urandom);
        parity_type_i = 1'($urandom);
        stop_size_i   = 2'($urandom);
        ticks(12);
        for (int i = 0; i < nb; i++) begin rx_i = data[i]; ticks(16); end
        if (pen) begin rx_i = par_sent; ticks(16); end
        for (int i = 0; i < ns; i++) begin rx_i = stops[i]; ticks(16); end
        if (idle > 0) begin rx_i = 1'b1; ticks(idle); end
    endtask

    task automatic recv(input string tag, input word_t exp);
        int    cyc;
        word_t got;
        cyc = 0;
        while (obs_q.size() == 0 && cyc < 3000) begin @(negedge clk); cyc++; end
        check({tag, " arrived"}, 32'(obs_q.size() > 0), 32'd1);
        if (obs_q.size() > 0) begin
            got = obs_q.pop_front();
            check({tag, " data"}, 32'(got.d), 32'(exp.d));
            check({tag, " parity_err"}, 32'(got.pe), 32'(exp.pe));
            check({tag, " frame_err"}, 32'(got.fe), 32'(exp.fe));
        end
    endtask

    word_t      exp_w;
    int         vc0, ov0;
    logic [3:0] r_ds;
    logic       r_pen, r_pev, r_par;
    logic [1:0] r_ss, r_stops;
    logic [8:0] r_data, r_mask;

    initial begin
        rx_if.rx_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        check("reset rx_valid", 32'(rx_if.rx_valid_o), 32'd0);
        check("reset data", 32'(rx_if.data_o), 32'd0);
        check("reset busy", 32'(rx_busy_o), 32'd0);
        check("reset overrun", 32'(rx_if.overrun_o), 32'd0);
        check("reset parity_err", 32'(rx_if.parity_err_o), 32'd0);
        check("reset frame_err", 32'(rx_if.frame_err_o), 32'd0);
        rst_ni = 1'b1;
        ticks(20);

        // 8N1 0xA5
        vc0 = valid_cycles;
        exp_w = model(4'd8, 1'b0, 1'b0, 2'd0, 9'h0A5, 1'b0, 2'b11);
        send_frame(4'd8, 1'b0, 1'b0, 2'd0, 9'h0A5, 1'b0, 2'b11, 16);
        recv("8N1 A5", exp_w);
        repeat (3) @(negedge clk);
        check("8N1 valid cycles", 32'(valid_cycles - vc0), 32'd1);

        // 7E1 0x35 with a wrong parity bit
        exp_w = model(4'd7, 1'b1, 1'b1, 2'd0, 9'h035, 1'b1, 2'b11);
        send_frame(4'd7, 1'b1, 1'b1, 2'd0, 9'h035, 1'b1, 2'b11, 16);
        recv("7E1 bad parity", exp_w);

        // 9O2 0x1C3 with correct parity, second stop bit low
        r_par = par_rule(9'h1C3, 1'b0);
        exp_w = model(4'd9, 1'b1, 1'b0, 2'd2, 9'h1C3, r_par, 2'b01);
        send_frame(4'd9, 1'b1, 1'b0, 2'd2, 9'h1C3, r_par, 2'b01, 16);
        recv("9O2 stop err", exp_w);

        // False start
        vc0 = valid_cycles;
        rx_i = 1'b0; ticks(3);
        rx_i = 1'b1; ticks(20);
        check("false start busy", 32'(rx_busy_o), 32'd0);
        check("false start no valid", 32'(valid_cycles - vc0), 32'd0);
        exp_w = model(4'd8, 1'b0, 1'b0, 2'd0, 9'h05A, 1'b0, 2'b11);
        send_frame(4'd8, 1'b0, 1'b0, 2'd0, 9'h05A, 1'b0, 2'b11, 16);
        recv("after false start", exp_w);

        // Overrun: two back-to-back frames with the consumer stalled
        set_ready(1'b0);
        ov0 = ovr_pulses;
        send_frame(4'd8, 1'b0, 1'b0, 2'd0, 9'h011, 1'b0, 2'b11, 0);
        send_frame(4'd8, 1'b0, 1'b0, 2'd0, 9'h022, 1'b0, 2'b11, 16);
        check("overrun valid held", 32'(rx_if.rx_valid_o), 32'd1);
        check("overrun data held", 32'(rx_if.data_o), 32'h011);
        check("overrun pulses", 32'(ovr_pulses - ov0), 32'd1);
        set_ready(1'b1);
        repeat (3) @(negedge clk);
        check("overrun valid drop", 32'(rx_if.rx_valid_o), 32'd0);
        exp_w = model(4'd8, 1'b0, 1'b0, 2'd0, 9'h011, 1'b0, 2'b11);
        recv("overrun kept word", exp_w);
        ticks(40);
        check("overrun dropped word", 32'(obs_q.size()), 32'd0);

        // Reset in the middle of data bits
        data_size_i = 4'd8; parity_size_i = 1'b0; stop_size_i = 2'd0;
        rx_i = 1'b0; ticks(16);
        rx_i = 1'b1; ticks(16);
        rx_i = 1'b0; ticks(8);
        check("pre-reset busy", 32'(rx_busy_o), 32'd1);
        rst_ni = 1'b0;
        @(negedge clk);
        check("mid reset valid", 32'(rx_if.rx_valid_o), 32'd0);
        check("mid reset data", 32'(rx_if.data_o), 32'd0);
        check("mid reset busy", 32'(rx_busy_o), 32'd0);
        check("mid reset flags", 32'({rx_if.parity_err_o, rx_if.frame_err_o, rx_if.overrun_o}), 32'd0);
        rst_ni = 1'b1;
        rx_i = 1'b1; ticks(20);
        exp_w = model(4'd8, 1'b0, 1'b0, 2'd0, 9'h03C, 1'b0, 2'b11);
        send_frame(4'd8, 1'b0, 1'b0, 2'd0, 9'h03C, 1'b0, 2'b11, 16);
        recv("after reset", exp_w);

        // Enable dropped mid-frame
        rx_i = 1'b0; ticks(16);
        rx_i = 1'b1; ticks(16);
        rx_i = 1'b0; ticks(8);
        en_i = 1'b0; ticks(1);
        check("disable busy", 32'(rx_busy_o), 32'd0);
        rx_i = 1'b1; ticks(4);
        en_i = 1'b1; ticks(16);
        check("disable no word", 32'(obs_q.size()), 32'd0);
        r_par = par_rule(9'h096, 1'b1);
        exp_w = model(4'd9, 1'b1, 1'b1, 2'd2, 9'h096, r_par, 2'b11);
        send_frame(4'd9, 1'b1, 1'b1, 2'd2, 9'h096, r_par, 2'b11, 16);
        recv("after disable", exp_w);

        // Break: all-zero frame, line then held low
        exp_w = model(4'd8, 1'b0, 1'b0, 2'd0, 9'h000, 1'b0, 2'b00);
        send_frame(4'd8, 1'b0, 1'b0, 2'd0, 9'h000, 1'b0, 2'b00, 0);
        ticks(48);
        recv("break", exp_w);
        check("break no restart", 32'(rx_busy_o), 32'd0);
        rx_i = 1'b1; ticks(20);
        check("break no extra word", 32'(obs_q.size()), 32'd0);

        // Randomized frames
        for (int k = 0; k < 12; k++) begin
            r_ds    = 4'($urandom_range(5, 15));
            r_pen   = 1'($urandom);
            r_pev   = 1'($urandom);
            r_ss    = 2'($urandom);
            r_data  = 9'($urandom);
            r_stops = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
            r_mask  = 9'((1 << nbits_of(r_ds)) - 1);
            r_par   = par_rule(r_data & r_mask, r_pev) ^ ($urandom_range(0, 3) == 0);
            exp_w   = model(r_ds, r_pen, r_pev, r_ss, r_data, r_par, r_stops);
            send_frame(r_ds, r_pen, r_pev, r_ss, r_data, r_par, r_stops, 16);
            recv("random", exp_w);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete, %0d tests run", n_tests);
        $fatal(1, "watchdog expired");
    end

endmodule
